// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types, constants and helpers for the Ascon permutation
package ascon_pkg;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perm_state_e;

    localparam int ROUNDS_A = 12;
    localparam int ROUNDS_B = 6;

    function automatic logic [7:0] rc_const(input logic [3:0] i);
        return {4'(4'd15 - i), i};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_ps.sv
// rtl/ascon_ps.sv - 5-bit Ascon S-box in its bit-sliced boolean form
module ascon_ps (
    input  logic [4:0] sbox_in,
    output logic [4:0] sbox_out
);

    logic a0, a1, a2, a3, a4;
    logic t0, t1, t2, t3, t4;

    always_comb begin
        a0 = sbox_in[4];
        a1 = sbox_in[3];
        a2 = sbox_in[2];
        a3 = sbox_in[1];
        a4 = sbox_in[0];

        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;

        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;

        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;

        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;

        sbox_out = {a0, a1, a2, a3, a4};
    end

endmodule

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant, substitution, diffusion
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state_in,
    input  logic [3:0]   round_idx,
    output ascon_state_t state_out
);

    ascon_state_t added;
    ascon_state_t subst;
    logic [4:0]   sb_in  [64];
    logic [4:0]   sb_out [64];

    always_comb begin
        added         = state_in;
        added.x2[7:0] = state_in.x2[7:0] ^ rc_const(round_idx);
    end

    // Column j of the five words forms one S-box input, x0 as MSB.
    for (genvar j = 0; j < 64; j++) begin : g_sbox
        assign sb_in[j] = {added.x0[j], added.x1[j], added.x2[j], added.x3[j], added.x4[j]};
        ascon_ps u_ps (
            .sbox_in  (sb_in[j]),
            .sbox_out (sb_out[j])
        );
    end

    always_comb begin
        subst = '0;
        for (int j = 0; j < 64; j++) begin
            subst.x0[j] = sb_out[j][4];
            subst.x1[j] = sb_out[j][3];
            subst.x2[j] = sb_out[j][2];
            subst.x3[j] = sb_out[j][1];
            subst.x4[j] = sb_out[j][0];
        end
    end

    always_comb begin
        state_out.x0 = subst.x0 ^ ror64(subst.x0, 19) ^ ror64(subst.x0, 28);
        state_out.x1 = subst.x1 ^ ror64(subst.x1, 61) ^ ror64(subst.x1, 39);
        state_out.x2 = subst.x2 ^ ror64(subst.x2, 1)  ^ ror64(subst.x2, 6);
        state_out.x3 = subst.x3 ^ ror64(subst.x3, 10) ^ ror64(subst.x3, 17);
        state_out.x4 = subst.x4 ^ ror64(subst.x4, 7)  ^ ror64(subst.x4, 41);
    end

endmodule

// File: rtl/ascon_perm_core.sv
// rtl/ascon_perm_core.sv - iterative Ascon p^a/p^b engine with start/done handshake
module ascon_perm_core
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [319:0] state_o
);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $error("ascon_perm_core: UNROLL must be 1 or 2");
    end

    localparam logic [3:0] STEP     = 4'(UNROLL);
    localparam logic [3:0] RC_FINAL = 4'(ROUNDS_A);

    perm_state_e  fsm_q, fsm_d;
    ascon_state_t state_q;
    logic [3:0]   rc_q;
    logic [3:0]   rc_init;
    logic         load;
    logic         step;
    ascon_state_t stage [UNROLL+1];

    // The round counter runs up to 12 so the last applied index is always 11.
    always_comb begin
        if (rounds_i == 4'd6) begin
            rc_init = 4'(ROUNDS_A - ROUNDS_B);
        end else if (rounds_i == 4'd8) begin
            rc_init = 4'(ROUNDS_A - 8);
        end else begin
            rc_init = 4'd0;
        end
    end

    assign stage[0] = state_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        ascon_round u_round (
            .state_in  (stage[k]),
            .round_idx (rc_q + 4'(k)),
            .state_out (stage[k+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        load  = 1'b0;
        step  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    fsm_d = ST_RUN;
                    load  = 1'b1;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (rc_q + STEP == RC_FINAL) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    fsm_d = ST_RUN;
                    load  = 1'b1;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            rc_q    <= 4'd0;
        end else if (load) begin
            state_q <= ascon_state_t'(state_i);
            rc_q    <= rc_init;
        end else if (step) begin
            state_q <= stage[UNROLL];
            rc_q    <= rc_q + STEP;
        end
    end

    assign busy_o  = (fsm_q == ST_RUN);
    assign done_o  = (fsm_q == ST_DONE);
    assign state_o = state_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// tb/tb_ascon_perm_core.sv - randomized checks of UNROLL=1 and UNROLL=2 cores against a table-driven model
module tb_ascon_perm_core;

    logic         clk;
    logic         rst_n;
    logic         start1, start2;
    logic [3:0]   rounds;
    logic [319:0] st_in;
    logic         busy1, done1, busy2, done2;
    logic [319:0] so1, so2;

    int ncmp  = 0;
    int nfail = 0;

    localparam logic [4:0] SBOX [32] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
    };

    ascon_perm_core #(.UNROLL(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start1),
        .rounds_i (rounds),
        .state_i  (st_in),
        .busy_o   (busy1),
        .done_o   (done1),
        .state_o  (so1)
    );

    ascon_perm_core #(.UNROLL(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start2),
        .rounds_i (rounds),
        .state_i  (st_in),
        .busy_o   (busy2),
        .done_o   (done2),
        .state_o  (so2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic int rounds_of(input logic [3:0] r);
        if (r == 4'd6) return 6;
        if (r == 4'd8) return 8;
        return 12;
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        int          idx;
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
            for (int w = 0; w < 5; w++) y[w] = 64'd0;
            for (int j = 0; j < 64; j++) begin
                idx = 0;
                for (int w = 0; w < 5; w++) idx = idx * 2 + int'(x[w][j]);
                v = SBOX[idx];
                for (int w = 0; w < 5; w++) y[w][j] = v[4 - w];
            end
            x[0] = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
            x[1] = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
            x[2] = y[2] ^ rot(y[2], 1)  ^ rot(y[2], 6);
            x[3] = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
            x[4] = y[4] ^ rot(y[4], 7)  ^ rot(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_both(input string tag, input logic [3:0] r, input logic [319:0] s);
        int           n;
        int           lat1, lat2, cnt1, cnt2;
        logic [319:0] got1, got2, exp;
        n    = rounds_of(r);
        exp  = ref_perm(s, n);
        lat1 = -1; lat2 = -1; cnt1 = 0; cnt2 = 0;
        got1 = '0; got2 = '0;
        rounds = r;
        st_in  = s;
        start1 = 1'b1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        st_in  = rand320();
        check({tag, "_busy1"}, 320'(busy1), 320'd1);
        check({tag, "_busy2"}, 320'(busy2), 320'd1);
        for (int k = 1; k <= n + 2; k++) begin
            @(posedge clk); #1;
            if (done1) begin
                cnt1++;
                if (lat1 < 0) begin lat1 = k; got1 = so1; end
            end
            if (done2) begin
                cnt2++;
                if (lat2 < 0) begin lat2 = k; got2 = so2; end
            end
        end
        check({tag, "_lat1"},   320'(lat1), 320'(n));
        check({tag, "_cnt1"},   320'(cnt1), 320'd1);
        check({tag, "_state1"}, got1, exp);
        check({tag, "_lat2"},   320'(lat2), 320'(n / 2));
        check({tag, "_cnt2"},   320'(cnt2), 320'd1);
        check({tag, "_state2"}, got2, exp);
    endtask

    initial begin
        logic [319:0] exp_q [$];
        logic [319:0] exp_v;
        logic [3:0]   rsel [4];
        int           dcnt;

        rsel[0] = 4'd12; rsel[1] = 4'd3; rsel[2] = 4'd0; rsel[3] = 4'd15;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        rounds = 4'd12;
        st_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  {318'd0, busy1, busy2}, 320'd0);
        check("reset_done",  {318'd0, done1, done2}, 320'd0);
        check("reset_state1", so1, 320'd0);
        check("reset_state2", so2, 320'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_both("p12_zero", 4'd12, 320'd0);
        run_both("p6_rand",  4'd6,  rand320());
        run_both("p8_rand",  4'd8,  rand320());
        run_both("p3_as12",  4'd3,  rand320());
        run_both("p12_rand", 4'd12, rand320());

        // Start held high: the UNROLL=1 core accepts every 13th edge only.
        for (int e = 0; e < 52; e++) begin
            st_in  = rand320();
            rounds = rsel[$urandom_range(0, 3)];
            start1 = 1'b1;
            if (e % 13 == 0) exp_q.push_back(ref_perm(st_in, 12));
            @(posedge clk); #1;
            if (e % 13 == 12) begin
                exp_v = exp_q.pop_front();
                check("b2b_done", 320'(done1), 320'd1);
                check("b2b_state", so1, exp_v);
                check("b2b_busy_in_done", 320'(busy1), 320'd0);
            end else begin
                check("b2b_no_done", 320'(done1), 320'd0);
                check("b2b_busy", 320'(busy1), 320'd1);
            end
        end
        start1 = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", 320'(busy1), 320'd0);

        rounds = 4'd12;
        st_in  = rand320();
        start1 = 1'b1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   {318'd0, busy1, busy2}, 320'd0);
        check("abort_done",   {318'd0, done1, done2}, 320'd0);
        check("abort_state1", so1, 320'd0);
        check("abort_state2", so2, 320'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done1 || done2 || busy1 || busy2) dcnt++;
        end
        check("abort_quiet", 320'(dcnt), 320'd0);
        run_both("after_abort", 4'd12, rand320());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
